qadd_sched: RTL and testbench

Round-robin scheduler sharing one `qadd` sign-magnitude fixed-point adder among `NREQ` requesters. It accepts one operand pair at a time through a valid/ready handshake and registers the operands. It evaluates the adder on a registered stage and returns the sum tagged with the requester index, plus an overflow flag. It sits between the fixed-point multiply/divide front ends and the single adder instance.

---
 rtl/qfix_pkg.sv | 26 ++
 rtl/qadd.sv | 33 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/qadd_sched.sv | 113 +++++++++++
 tb/tb_qadd_sched.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qfix_pkg.sv
// Shared definitions for the sign-magnitude fixed-point adder scheduler.
`timescale 1ns/1ps
package qfix_pkg;

  localparam int QFIX_Q = 19;
  localparam int QFIX_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  // Helpers take a word zero-extended to 64 bits plus its real width n,
  // so one definition serves any N up to 64.
  function automatic logic qfix_sign(input logic [63:0] x, input int n);
    return x[n-1];
  endfunction

  function automatic logic [63:0] qfix_mag(input logic [63:0] x, input int n);
    logic [63:0] mask;
    mask = (64'd1 << (n - 1)) - 64'd1;
    return x & mask;
  endfunction

endpackage

// File: rtl/qadd.sv
// Sign-magnitude fixed-point adder; magnitude wraps on overflow.
`timescale 1ns/1ps
module qadd #(
  parameter int Q = 19,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  logic          sa, sb;
  logic [N-2:0]  ma, mb;

  // Magnitudes assembled from their integer and fractional fields.
  assign sa = a[N-1];
  assign sb = b[N-1];
  assign ma = {a[N-2:Q], a[Q-1:0]};
  assign mb = {b[N-2:Q], b[Q-1:0]};

  // Add on equal signs, otherwise subtract the smaller magnitude from the larger.
  always_comb begin
    c = '0;
    if (sa == sb) begin
      c = {sa, ma + mb};
    end else if (ma > mb) begin
      c = {sa, ma - mb};
    end else begin
      c = {sb, mb - ma};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest requesting index at or after ptr, wrapping.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  int idx;

  // Scan from ptr upward; the first valid requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any && valid[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/qadd_sched.sv
// Round-robin scheduler sharing one qadd among NREQ requesters.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | granting; operands latched on the request handshake
//   ST_EXEC | qadd evaluates a_r+b_r, result registered
//   ST_RESP | result held on res_* until res_ready
`timescale 1ns/1ps
module qadd_sched
  import qfix_pkg::*;
#(
  parameter int Q    = QFIX_Q,
  parameter int N    = QFIX_N,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      res_valid,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [N-1:0]              res_c,
  output logic                      res_ovf,
  input  logic                      res_ready
);

  localparam int IDW = $clog2(NREQ);

  sched_state_e   state, state_nxt;
  logic [IDW-1:0] ptr, gnt_id, id_r;
  logic [NREQ-1:0] gnt;
  logic           any;
  logic           hs;
  logic [N-1:0]   a_r, b_r, sum;
  logic [N-2:0]   mag_a, mag_b;
  logic           ovf;
  logic           sum_zero;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid  (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  qadd #(.Q(Q), .N(N)) u_qadd (
    .a (a_r),
    .b (b_r),
    .c (sum)
  );

  // Carry out of the magnitude field happens exactly when mag_a exceeds ~mag_b.
  assign mag_a    = (N-1)'(qfix_mag(64'(a_r), N));
  assign mag_b    = (N-1)'(qfix_mag(64'(b_r), N));
  assign ovf      = (qfix_sign(64'(a_r), N) == qfix_sign(64'(b_r), N)) && (mag_a > ~mag_b);
  assign sum_zero = (qfix_mag(64'(sum), N) == 64'd0);

  assign res_valid = (state == ST_RESP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and grant; req_ready is masked during reset so no handshake is seen.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    hs        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst && any) begin
          req_ready = gnt;
          hs        = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, pointer advance and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      id_r    <= '0;
      res_id  <= '0;
      res_c   <= '0;
      res_ovf <= 1'b0;
    end else begin
      if (hs) begin
        a_r  <= req_a[int'(gnt_id)*N +: N];
        b_r  <= req_b[int'(gnt_id)*N +: N];
        id_r <= gnt_id;
        ptr  <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
      if (state == ST_EXEC) begin
        res_c   <= sum_zero ? '0 : sum;
        res_id  <= id_r;
        res_ovf <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_qadd_sched.sv
// Scoreboard bench for qadd_sched.
`timescale 1ns/1ps
module tb_qadd_sched;

  localparam int N    = 32;
  localparam int Q    = 19;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [N-1:0]      res_c;
  logic              res_ovf;
  logic              res_ready;

  typedef struct {
    int          id;
    logic [31:0] c;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  qadd_sched #(.Q(Q), .N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_c     (res_c),
    .res_ovf   (res_ovf),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference sign-magnitude add: {ovf, c}.
  function automatic logic [32:0] sm_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, s;
    logic        sign;
    ma = {1'b0, a[30:0]};
    mb = {1'b0, b[30:0]};
    if (a[31] == b[31]) begin
      s = ma + mb;
      sign = a[31];
      return {s[31], ((s[30:0] == 31'd0) ? 1'b0 : sign), s[30:0]};
    end
    if (ma > mb) begin s = ma - mb; sign = a[31]; end
    else         begin s = mb - ma; sign = b[31]; end
    if (s == 32'd0) sign = 1'b0;
    return {1'b0, sign, s[30:0]};
  endfunction

  // Result monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_res", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_id", 64'(res_id), 64'(e.id));
        chk("res_c", 64'(res_c), 64'(e.c));
        chk("res_ovf", 64'(res_ovf), 64'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
  endtask

  task automatic push(input int id, input logic [31:0] c, input logic ovf);
    exp_t e;
    e.id = id; e.c = c; e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Single request from one requester with explicit expected result.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_c, input logic exp_ovf);
    bit hs = 0;
    set_ops(id, a, b);
    req_valid[id] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        push(id, exp_c, exp_ovf);
        hs = 1;
      end
      tick();
      if (hs) break;
    end
    req_valid[id] = 1'b0;
    if (!hs) chk("hs_timeout", 0, 1);
  endtask

  // Hold a request mask and check grant order (nibble k = expected k-th grant).
  task automatic serve(input logic [NREQ-1:0] mask, input int n, input logic [31:0] ord);
    int k = 0;
    int g;
    logic [32:0] m;
    req_valid = mask;
    for (int cyc = 0; cyc < 100 && k < n; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rdy_onehot", 64'($countones(req_ready)), 1);
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        chk("grant_order", 64'(g), 64'(ord[k*4 +: 4]));
        m = sm_add(req_a[g*N +: N], req_b[g*N +: N]);
        push(g, m[31:0], m[32]);
        k++;
      end
      tick();
    end
    req_valid = '0;
    if (k < n) chk("grant_timeout", 64'(k), 64'(n));
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid) break;
    end
    chk("drain", 64'(sb.size()), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] c0;
    logic [IDW-1:0] id0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_res_valid", 64'(res_valid), 0);
    chk("rst_res_id", 64'(res_id), 0);
    chk("rst_res_c", 64'(res_c), 0);
    chk("rst_res_ovf", 64'(res_ovf), 0);
    tick();
    rst = 1'b0;

    // Fairness from reset: all four held high.
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i) << Q, 32'h80040000);
    serve(4'b1111, 5, 32'h00003210);
    drain();

    // Single op with latency check.
    issue(2, 32'h000C0000, 32'h80040000, 32'h00080000, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (res_valid) break;
    end
    chk("latency", 64'(n), 2);
    drain();

    // Backpressure.
    res_ready = 1'b0;
    issue(1, 32'h00200000, 32'h00100000, 32'h00300000, 1'b0);
    set_ops(3, 32'h00010000, 32'h00010000);
    req_valid[3] = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) break;
      n++;
    end
    chk("bp_wait", 64'(n), 1);
    c0 = res_c; id0 = res_id;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(res_valid), 1);
      chk("bp_req_ready", 64'(req_ready), 0);
      chk("bp_c_stable", 64'(res_c), 64'(c0));
      chk("bp_id_stable", 64'(res_id), 64'(id0));
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_idle", 64'(res_valid), 0);
    chk("bp_next_grant", 64'(req_ready), 64'(4'b1000));
    push(3, 32'h00020000, 1'b0);
    tick();
    req_valid[3] = 1'b0;
    drain();

    // Overflow, both signs.
    issue(0, 32'h7FF80000, 32'h00100000, 32'h00080000, 1'b1);
    drain();
    issue(1, 32'hFFF80000, 32'h80100000, 32'h80080000, 1'b1);
    drain();

    // Negative zero.
    issue(3, 32'h00080000, 32'h80080000, 32'h00000000, 1'b0);
    drain();

    // Reset while in EXEC discards the op.
    issue(0, 32'h00100000, 32'h00100000, 32'h00200000, 1'b0);
    rst = 1'b1;
    sb.delete();
    tick();
    @(negedge clk);
    chk("mid_rst_valid", 64'(res_valid), 0);
    chk("mid_rst_id", 64'(res_id), 0);
    chk("mid_rst_c", 64'(res_c), 0);
    chk("mid_rst_ovf", 64'(res_ovf), 0);
    chk("mid_rst_ready", 64'(req_ready), 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(res_valid), 0);
    end
    tick();
    // ptr back at 0: requester 0 wins over 1.
    set_ops(0, 32'h00040000, 32'h00040000);
    set_ops(1, 32'h80100000, 32'h00040000);
    serve(4'b0011, 2, 32'h00000010);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
